// File: rtl/multiplexer_2to1.sv
// multiplexer_2to1
//   Clocked 2-to-1 data steering primitive with select history for debug.
//   y = x ? b : a across all WIDTH bits. A registered copy of the select
//   (sel_q) and a saturating count of select changes (switch_cnt) are kept
//   in every build.
//
// Build option:
//   MULTIPLEXER_2TO1_OUTREG_EN defined   -> y is registered (1-cycle latency,
//                                           cleared by rst)
//   MULTIPLEXER_2TO1_OUTREG_EN undefined -> y is combinational (0 latency,
//                                           rst has no effect on y)
//
// Parameters:
//   WIDTH : data width of a, b, y (1..64)
//   CNT_W : width of the select-change counter (1..32)
//
// Ports:
//   clk        : clock, rising edge active
//   rst        : asynchronous active-high reset
//   a          : data selected when x = 0
//   b          : data selected when x = 1
//   x          : select
//   y          : multiplexed output
//   sel_q      : x sampled at the last rising edge
//   switch_cnt : number of select transitions since reset, saturating
module multiplexer_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             x,
  output logic [WIDTH-1:0] y,
  output logic             sel_q,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] y_sel;

  // An unknown select propagates as X in simulation instead of silently
  // picking one input.
  always_comb begin
    y_sel = a;
    case (x)
      1'b0:    y_sel = a;
      1'b1:    y_sel = b;
      default: y_sel = {WIDTH{1'bx}};
    endcase
  end

  // The first edge after reset release compares x against the cleared
  // sel_q, so x=1 at that edge counts as one switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= 1'b0;
      switch_cnt <= '0;
    end else begin
      sel_q <= x;
      if ((x != sel_q) && (switch_cnt != CNT_MAX)) begin
        switch_cnt <= switch_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MULTIPLEXER_2TO1_OUTREG_EN
  logic [WIDTH-1:0] y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_sel;
    end
  end

  assign y = y_q;
`else
  assign y = y_sel;
`endif

endmodule

// File: tb/tb_multiplexer_2to1.sv
module tb_multiplexer_2to1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       x  = 1'b0;

  logic [7:0] y8;
  logic       sel8;
  logic [1:0] cnt8;
  logic       y1;
  logic       sel1;
  logic [7:0] cnt1;

  always #5 clk = ~clk;

  multiplexer_2to1 #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .x(x),
    .y(y8), .sel_q(sel8), .switch_cnt(cnt8)
  );

  multiplexer_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .x(x),
    .y(y1), .sel_q(sel1), .switch_cnt(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: select history as plain integers
  localparam int CMAX8 = (1 << 2) - 1;
  localparam int CMAX1 = (1 << 8) - 1;
  int         m_sel  = 0;
  int         m_cnt8 = 0;
  int         m_cnt1 = 0;
  logic [7:0] m_y8r  = '0;
  logic       m_y1r  = 1'b0;

  typedef struct {
    logic a;
    logic b;
    logic x;
    logic y;
  } tt_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_y8();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
    return m_y8r;
`else
    return x ? b8 : a8;
`endif
  endfunction

  function automatic logic exp_y1();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
    return m_y1r;
`else
    return x ? b1 : a1;
`endif
  endfunction

  task automatic check_all();
    chk("y8", y8, exp_y8());
    chk("y1", y1, exp_y1());
    chk("sel_q8", sel8, m_sel);
    chk("sel_q1", sel1, m_sel);
    chk("switch_cnt8", cnt8, m_cnt8);
    chk("switch_cnt1", cnt1, m_cnt1);
  endtask

  task automatic drive(input logic [7:0] a8v, input logic [7:0] b8v,
                       input logic a1v, input logic b1v, input logic xv);
    a8 = a8v; b8 = b8v; a1 = a1v; b1 = b1v; x = xv;
    #1;
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (!rst) begin
      if (int'(x) != m_sel) begin
        if (m_cnt8 < CMAX8) m_cnt8++;
        if (m_cnt1 < CMAX1) m_cnt1++;
      end
      m_sel = int'(x);
      m_y8r = x ? b8 : a8;
      m_y1r = x ? b1 : a1;
    end
    #1;
    check_all();
  endtask

  // rst pulse placed between edges and held across one edge
  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    #1;
    m_sel = 0; m_cnt8 = 0; m_cnt1 = 0; m_y8r = '0; m_y1r = 1'b0;
    check_all();
    chk("rst_sel_q", sel8, 0);
    chk("rst_cnt", cnt8, 0);
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
    chk("rst_y", y8, 0);
`endif
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    tt_vec_t    tt[8];
    int         exp_cnt[5];
    int         saved8, saved1;
    logic [7:0] ra, rb;

    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_cnt = '{1, 2, 3, 3, 3};

    // reset state
    #2;
    check_all();
    chk("init_sel_q", sel8, 0);
    chk("init_cnt", cnt8, 0);
    #6;
    rst = 1'b0;

    // truth table
    for (int i = 0; i < 8; i++) begin
      drive({8{tt[i].a}}, {8{tt[i].b}}, tt[i].a, tt[i].b, tt[i].x);
`ifndef MULTIPLEXER_2TO1_OUTREG_EN
      chk("tt_y1", y1, tt[i].y);
      chk("tt_y8", y8, {8{tt[i].y}});
`endif
      edge_step();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
      chk("tt_y1", y1, tt[i].y);
      chk("tt_y8", y8, {8{tt[i].y}});
`endif
    end

    // saturation of the 2-bit counter
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      drive(8'h11, 8'h22, 1'b0, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
      edge_step();
      chk("sat_cnt", cnt8, exp_cnt[i]);
      chk("sat_sel_q", sel8, (i % 2 == 0) ? 1 : 0);
    end

    // registered steering, x high for one cycle
    drive(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0);
`ifndef MULTIPLEXER_2TO1_OUTREG_EN
    chk("steer_y0", y8, 8'h5A);
`endif
    edge_step();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
    chk("steer_y0", y8, 8'h5A);
`endif
    drive(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b1);
`ifndef MULTIPLEXER_2TO1_OUTREG_EN
    chk("steer_y1", y8, 8'hC3);
`endif
    edge_step();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
    chk("steer_y1", y8, 8'hC3);
`endif
    drive(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0);
    edge_step();
    chk("steer_y2", y8, 8'h5A);

    // async reset mid-operation with count 2 and y = C3
    rst_pulse();
    drive(8'hC3, 8'hC3, 1'b1, 1'b1, 1'b1);
    edge_step();
    drive(8'hC3, 8'hC3, 1'b1, 1'b1, 1'b0);
    edge_step();
    chk("pre_rst_cnt", cnt8, 2);
    chk("pre_rst_y", y8, 8'hC3);
    rst_pulse();
    drive(8'hC3, 8'h3C, 1'b1, 1'b0, 1'b1);
    edge_step();
    chk("post_rst_cnt", cnt8, 1);
    chk("post_rst_cnt1", cnt1, 1);

    // data-only activity with x held high
    saved8 = m_cnt8;
    saved1 = m_cnt1;
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      drive(8'($urandom), rb, 1'($urandom), 1'($urandom), 1'b1);
      edge_step();
`ifdef MULTIPLEXER_2TO1_OUTREG_EN
      chk("data_y_tracks_b", y8, rb);
`endif
    end
    chk("data_cnt8_hold", cnt8, saved8);
    chk("data_cnt1_hold", cnt1, saved1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
      edge_step();
      if ($urandom_range(0, 59) == 0) rst_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
